minsec_timer: RTL and testbench
===============================

MINSEC_TIMER -- requirements
Module: minsec_timer

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: clk_50mHz cycles per display digit slot.
REQ-002 SHALL provide port clk_50mHz, input, 1 bit: sole clock; every flop samples on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL provide port clk_1Hz, input, 1 bit: slow square wave from the divider stage.
- Treated as data, never as a clock.
REQ-005 SHALL provide port run, input, 1 bit: count enable, level.
REQ-006 SHALL provide port clr, input, 1 bit: synchronous clear, level.
REQ-007 SHALL provide port sec_lo, output, 4 bits: seconds units, BCD 0-9.
REQ-008 SHALL provide port sec_hi, output, 3 bits: seconds tens, 0-5.
REQ-009 SHALL provide port min_lo, output, 4 bits: minutes units, BCD 0-9.
REQ-010 SHALL provide port min_hi, output, 3 bits: minutes tens, 0-5.
REQ-011 SHALL provide port wrap, output, 1 bit: single-cycle pulse on 59:59 -> 00:00.
REQ-012 SHALL provide port an, output, 4 bits: digit enables, active-low, one-hot.
REQ-013 SHALL provide port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-014 SHALL synchronise clk_1Hz through two flops (s1, s2), then one history flop (s3).
REQ-015 SHALL form tick = s2 & ~s3: one cycle per clk_1Hz rising edge.
- Only rising edges count.
- High time and period of clk_1Hz do not matter.
REQ-016 SHALL update the digits on the third clk_50mHz rising edge after clk_1Hz is first sampled high.
- Edge 1 loads s1; edge 2 loads s2 (tick asserts); edge 3 updates the count.
REQ-017 SHALL advance the time by one second when tick=1, run=1 and clr=0.
- Otherwise the count holds.
- The synchroniser and edge detector keep tracking clk_1Hz regardless of run.
REQ-018 SHALL carry as follows:
- sec_lo 9 -> 0 increments sec_hi.
- sec_hi 5 with sec_lo 9 -> 0, and min_lo increments.
- min_lo 9 -> 0 increments min_hi.
- 59:59 -> 00:00.
REQ-019 SHALL assert wrap for exactly the cycle following the 59:59 -> 00:00 update; wrap is registered.
REQ-020 SHALL force all digits to 0 on the next edge when clr=1, irrespective of tick and run.
- clr takes priority over a simultaneous tick; that tick is lost.
- wrap stays 0 on a clear.
REQ-021 SHALL run a scan counter from 0 to SCAN_DIV-1 and a 2-bit digit index.
- The index increments when the counter is at SCAN_DIV-1.
- The index wraps 3 -> 0.
- The scan runs continuously, unaffected by run and clr.
REQ-022 SHALL map the digit index to an and the displayed value:
- Index 0: an=4'b1110, value sec_lo.
- Index 1: an=4'b1101, value sec_hi.
- Index 2: an=4'b1011, value min_lo.
- Index 3: an=4'b0111, value min_hi.
REQ-023 SHALL register an and seg so both change on the same edge as the index, with no glitch between them.
REQ-024 SHALL decode the selected value to seg as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-025 SHALL drive seg=1111111 (blank) for any undecoded value.

Reset
REQ-026 SHALL, while rst_n=0, hold the outputs and internal state at these values:
- Digits 0, wrap=0.
- s1=s2=s3=0.
- Scan counter 0, index 0.
- an=1110, seg=1000000.
REQ-027 SHALL apply reset immediately and asynchronously, including mid-count and mid-scan.
REQ-028 SHALL resume on the first clk_50mHz edge after rst_n rises.
- If clk_1Hz is already high when rst_n rises, that level SHALL produce one tick, taken as a rising edge.

Verification
REQ-029 SHALL cover basic count: SCAN_DIV=4, run=1, five clk_1Hz pulses -> sec_lo=5, and each update lands exactly 3 cycles after the clk_1Hz rise.
REQ-030 SHALL cover carry: preload to 09:59 via 599 ticks, one more tick -> min_hi=1, min_lo=0, sec_hi=0, sec_lo=0, wrap=0.
REQ-031 SHALL cover wrap-around: 3599 ticks to 59:59, one more tick -> 00:00 with wrap high for exactly 1 cycle.
REQ-032 SHALL cover hold/clear: run=0 during 3 ticks -> count unchanged; clr=1 coinciding with tick at 00:07 -> 00:00 next edge, no increment.
REQ-033 SHALL cover display scan: SCAN_DIV=4, time 12:34 -> an steps 1110/1101/1011/0111 every 4 cycles with seg 0011001, 0110000, 0100100, 1111001.
REQ-034 SHALL cover async reset: rst_n pulled low between clock edges at 00:42 -> outputs at reset values before the next edge; clk_1Hz held high through rst_n release -> exactly one increment.

Source files
------------

// File: rtl/minsec_timer.sv
`timescale 1ns/1ps
// Minutes:seconds counter advanced by a synchronised 1 Hz strobe, with a
// multiplexed active-low 4-digit seven-segment display driver.
module minsec_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_50mHz,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       run,
  input  logic       clr,
  output logic [3:0] sec_lo,
  output logic [2:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [2:0] min_hi,
  output logic       wrap,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic s1, s2, s3;
  logic tick;

  logic [3:0] sec_lo_n, min_lo_n;
  logic [2:0] sec_hi_n, min_hi_n;
  logic       wrap_n;

  logic [CW-1:0] scan_cnt, scan_cnt_n;
  logic [1:0]    idx, idx_n;
  logic [3:0]    disp_val;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // clk_1Hz is asynchronous data; s3 only remembers the previous level
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_1Hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_comb begin
    sec_lo_n = sec_lo;
    sec_hi_n = sec_hi;
    min_lo_n = min_lo;
    min_hi_n = min_hi;
    wrap_n   = 1'b0;
    if (clr) begin
      sec_lo_n = 4'd0;
      sec_hi_n = 3'd0;
      min_lo_n = 4'd0;
      min_hi_n = 3'd0;
    end else if (tick && run) begin
      if (sec_lo == 4'd9) begin
        sec_lo_n = 4'd0;
        if (sec_hi == 3'd5) begin
          sec_hi_n = 3'd0;
          if (min_lo == 4'd9) begin
            min_lo_n = 4'd0;
            if (min_hi == 3'd5) begin
              min_hi_n = 3'd0;
              wrap_n   = 1'b1;
            end else begin
              min_hi_n = min_hi + 3'd1;
            end
          end else begin
            min_lo_n = min_lo + 4'd1;
          end
        end else begin
          sec_hi_n = sec_hi + 3'd1;
        end
      end else begin
        sec_lo_n = sec_lo + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      sec_lo <= 4'd0;
      sec_hi <= 3'd0;
      min_lo <= 4'd0;
      min_hi <= 3'd0;
      wrap   <= 1'b0;
    end else begin
      sec_lo <= sec_lo_n;
      sec_hi <= sec_hi_n;
      min_lo <= min_lo_n;
      min_hi <= min_hi_n;
      wrap   <= wrap_n;
    end
  end

  always_comb begin
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_n = '0;
      idx_n      = idx + 2'd1;
    end else begin
      scan_cnt_n = scan_cnt + 1'b1;
      idx_n      = idx;
    end
  end

  // Display is built from next-state digits and index so an/seg always
  // match the digit outputs on the same cycle
  always_comb begin
    disp_val = 4'd0;
    an_n     = 4'b1111;
    case (idx_n)
      2'd0: begin an_n = 4'b1110; disp_val = sec_lo_n;         end
      2'd1: begin an_n = 4'b1101; disp_val = {1'b0, sec_hi_n}; end
      2'd2: begin an_n = 4'b1011; disp_val = min_lo_n;         end
      2'd3: begin an_n = 4'b0111; disp_val = {1'b0, min_hi_n}; end
      default: begin an_n = 4'b1111; disp_val = 4'd0;          end
    endcase
    seg_n = seg_decode(disp_val);
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= scan_cnt_n;
      idx      <= idx_n;
      an       <= an_n;
      seg      <= seg_n;
    end
  end

endmodule

// File: tb/tb_minsec_timer.sv
`timescale 1ns/1ps
// Self-checking bench for minsec_timer: a seconds-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_minsec_timer;

  localparam int SCAN_DIV = 4;

  logic       clk_50mHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk_1Hz   = 1'b0;
  logic       run       = 1'b1;
  logic       clr       = 1'b0;
  logic [3:0] sec_lo;
  logic [2:0] sec_hi;
  logic [3:0] min_lo;
  logic [2:0] min_hi;
  logic       wrap;
  logic [3:0] an;
  logic [6:0] seg;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_printed    = 0;

  minsec_timer #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_50mHz(clk_50mHz),
    .rst_n    (rst_n),
    .clk_1Hz  (clk_1Hz),
    .run      (run),
    .clr      (clr),
    .sec_lo   (sec_lo),
    .sec_hi   (sec_hi),
    .min_lo   (min_lo),
    .min_hi   (min_hi),
    .wrap     (wrap),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk_50mHz = ~clk_50mHz;

  // Reference model: elapsed seconds, edges since reset, pending update edges
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int m_time  = 0;
  int m_edges = 0;
  bit m_prev  = 1'b0;
  bit m_wrap  = 1'b0;
  int due_q[$];

  always @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      m_time  = 0;
      m_edges = 0;
      m_prev  = 1'b0;
      m_wrap  = 1'b0;
      due_q.delete();
    end else begin
      bit due;
      due = 1'b0;
      m_edges++;
      if (due_q.size() > 0 && due_q[0] == m_edges) begin
        due = 1'b1;
        void'(due_q.pop_front());
      end
      m_wrap = 1'b0;
      if (clr) m_time = 0;
      else if (due && run) begin
        m_wrap = (m_time == 3599);
        m_time = (m_time + 1) % 3600;
      end
      if (clk_1Hz && !m_prev) due_q.push_back(m_edges + 2);
      m_prev = clk_1Hz;
    end
  end

  always @(negedge clk_50mHz) begin
    int d [4];
    int idx;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    d[0] = (m_time % 60) % 10;
    d[1] = (m_time % 60) / 10;
    d[2] = (m_time / 60) % 10;
    d[3] = (m_time / 60) / 10;
    idx = (m_edges / SCAN_DIV) % 4;
    exp_an  = 4'b1111 ^ (4'b0001 << idx);
    exp_seg = seg_tab[d[idx]];
    n_compared++;
    if (sec_lo !== 4'(d[0]) || sec_hi !== 3'(d[1]) || min_lo !== 4'(d[2]) ||
        min_hi !== 3'(d[3]) || wrap !== m_wrap || an !== exp_an || seg !== exp_seg) begin
      n_mismatched++;
      if (n_printed < 10) begin
        n_printed++;
        $display("[TB] FAIL model_cycle t=%0t got %0d%0d:%0d%0d wrap=%b an=%b seg=%b required %0d%0d:%0d%0d wrap=%b an=%b seg=%b",
                 $time, min_hi, min_lo, sec_hi, sec_lo, wrap, an, seg,
                 d[3], d[2], d[1], d[0], m_wrap, exp_an, exp_seg);
      end
    end
  end

  task automatic check_output(input string name, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_time(input string name, input int mh, input int ml, input int sh, input int sl);
    check_output({name, "_min_hi"}, int'(min_hi), mh);
    check_output({name, "_min_lo"}, int'(min_lo), ml);
    check_output({name, "_sec_hi"}, int'(sec_hi), sh);
    check_output({name, "_sec_lo"}, int'(sec_lo), sl);
  endtask

  // One clk_1Hz pulse; returns 1 ns after the edge that applies its update
  task automatic apply_stimulus();
    @(negedge clk_50mHz) clk_1Hz = 1'b1;
    @(posedge clk_50mHz);
    @(posedge clk_50mHz);
    @(negedge clk_50mHz) clk_1Hz = 1'b0;
    @(posedge clk_50mHz) #1;
  endtask

  task automatic clear_count();
    @(negedge clk_50mHz) clr = 1'b1;
    @(negedge clk_50mHz) clr = 1'b0;
  endtask

  initial begin
    #1ms;
    n_mismatched++;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    logic [3:0] prev_an;
    bit         aligned;
    logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    repeat (3) @(negedge clk_50mHz);
    check_time("reset", 0, 0, 0, 0);
    check_output("reset_wrap", int'(wrap), 0);
    check_output("reset_an", int'(an), 4'b1110);
    check_output("reset_seg", int'(seg), 7'b1000000);
    rst_n = 1'b1;

    // Update lands on the third edge after clk_1Hz is first sampled high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50mHz) clk_1Hz = 1'b1;
      @(posedge clk_50mHz) #1;
      check_output("latency_edge1", int'(sec_lo), i);
      @(posedge clk_50mHz) #1;
      check_output("latency_edge2", int'(sec_lo), i);
      @(posedge clk_50mHz) #1;
      check_output("latency_edge3", int'(sec_lo), i + 1);
      @(negedge clk_50mHz) clk_1Hz = 1'b0;
      @(negedge clk_50mHz);
    end
    check_time("basic_count", 0, 0, 0, 5);

    clear_count();
    repeat (599) apply_stimulus();
    check_time("preload_0959", 0, 9, 5, 9);
    apply_stimulus();
    check_time("carry_1000", 1, 0, 0, 0);
    check_output("carry_wrap", int'(wrap), 0);

    clear_count();
    repeat (3599) apply_stimulus();
    check_time("preload_5959", 5, 9, 5, 9);
    apply_stimulus();
    check_time("wrap_0000", 0, 0, 0, 0);
    check_output("wrap_high", int'(wrap), 1);
    @(posedge clk_50mHz) #1;
    check_output("wrap_one_cycle", int'(wrap), 0);

    repeat (7) apply_stimulus();
    check_time("preload_0007", 0, 0, 0, 7);
    run = 1'b0;
    repeat (3) apply_stimulus();
    check_time("hold_run0", 0, 0, 0, 7);
    run = 1'b1;
    @(negedge clk_50mHz) clk_1Hz = 1'b1;
    @(posedge clk_50mHz);
    @(posedge clk_50mHz);
    @(negedge clk_50mHz) begin clk_1Hz = 1'b0; clr = 1'b1; end
    @(posedge clk_50mHz) #1;
    check_time("clr_over_tick", 0, 0, 0, 0);
    check_output("clr_wrap", int'(wrap), 0);
    @(negedge clk_50mHz) clr = 1'b0;
    repeat (4) @(posedge clk_50mHz);
    #1;
    check_time("clr_tick_lost", 0, 0, 0, 0);

    repeat (754) apply_stimulus();
    check_time("preload_1234", 1, 2, 3, 4);
    aligned = 1'b0;
    prev_an = an;
    for (int c = 0; c < 20 && !aligned; c++) begin
      @(posedge clk_50mHz) #1;
      if (an == 4'b1110 && prev_an != 4'b1110) aligned = 1'b1;
      prev_an = an;
    end
    check_output("scan_align", int'(aligned), 1);
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        check_output("scan_an", int'(an), int'(scan_an[g]));
        check_output("scan_seg", int'(seg), int'(scan_seg[g]));
        @(posedge clk_50mHz) #1;
      end
    end

    clear_count();
    repeat (42) apply_stimulus();
    check_time("preload_0042", 0, 0, 4, 2);
    @(posedge clk_50mHz) #2;
    rst_n = 1'b0;
    #1;
    check_time("async_reset", 0, 0, 0, 0);
    check_output("async_reset_wrap", int'(wrap), 0);
    check_output("async_reset_an", int'(an), 4'b1110);
    check_output("async_reset_seg", int'(seg), 7'b1000000);
    clk_1Hz = 1'b1;
    @(negedge clk_50mHz);
    @(negedge clk_50mHz) rst_n = 1'b1;
    repeat (2) @(posedge clk_50mHz);
    #1;
    check_output("release_edge2", int'(sec_lo), 0);
    @(posedge clk_50mHz) #1;
    check_output("release_edge3", int'(sec_lo), 1);
    repeat (6) @(posedge clk_50mHz);
    #1;
    check_output("release_single_tick", int'(sec_lo), 1);
    @(negedge clk_50mHz) clk_1Hz = 1'b0;

    repeat (5) @(negedge clk_50mHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
